// File: rtl/counter_pkg.sv
// Shared definitions for the up/down modulo counter: direction constants,
// the per-edge command encoding and the load-value clamp.
package counter_pkg;

  localparam logic CNT_UP   = 1'b1;
  localparam logic CNT_DOWN = 1'b0;

  typedef enum logic [1:0] {
    RST,
    LOAD,
    STEP,
    HOLD
  } cnt_cmd_e;

  // Wide enough for WIDTH=32 with MODULUS=2**32.
  function automatic logic [32:0] clampLoad(input logic [32:0] value,
                                            input logic [32:0] modulus);
    return (value < modulus) ? value : (modulus - 33'd1);
  endfunction

endpackage

// File: rtl/jk_sync_cell.sv
// One counter bit: synchronous JK flip-flop (hold/reset/set/toggle) with
// synchronous active-high reset to a per-bit value.
module jk_sync_cell #(
  parameter logic RST_BIT = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q
);

  logic r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= RST_BIT;
    end else begin
      case ({j, k})
        2'b01:   r_q <= 1'b0;
        2'b10:   r_q <= 1'b1;
        2'b11:   r_q <= ~r_q;
        default: r_q <= r_q;
      endcase
    end
  end

  assign q = r_q;

endmodule

// File: rtl/updown_counter_mod.sv
// Synchronous up/down modulo counter with load, enable, carry/borrow and a
// registered wrap pulse. Define UPDOWN_CNT_SAT_EN for saturating mode.
module updown_counter_mod
  import counter_pkg::*;
#(
  parameter int              WIDTH   = 5,
  parameter longint unsigned MODULUS = 32,
  parameter longint unsigned RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             co,
  output logic             wrap
);

  localparam logic [WIDTH:0]   MOD_EXT  = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_BITS = WIDTH'(RST_VAL);

  logic [WIDTH-1:0] w_q;
  logic [WIDTH:0]   w_inc;
  logic [WIDTH-1:0] w_dec;
  logic             w_atMax;
  logic             w_atZero;
  cnt_cmd_e         w_cmd;
  logic [WIDTH-1:0] w_nextQ;
  logic             w_nextWrap;
  logic             w_forceBits;
  logic             r_wrap;

  // Increment is done one bit wider so MODULUS = 2**WIDTH compares cleanly.
  assign w_inc    = {1'b0, w_q} + (WIDTH+1)'(1);
  assign w_dec    = w_q - WIDTH'(1);
  assign w_atMax  = (w_inc == MOD_EXT);
  assign w_atZero = (w_q == '0);

  assign tc = (up & w_atMax) | (~up & w_atZero);
  assign co = tc & en & ~load;

  always_comb begin
    if (rst)       w_cmd = RST;
    else if (load) w_cmd = LOAD;
    else if (en)   w_cmd = STEP;
    else           w_cmd = HOLD;
  end

  always_comb begin
    w_nextQ     = w_q;
    w_nextWrap  = 1'b0;
    w_forceBits = 1'b0;
    case (w_cmd)
      RST: begin
        w_nextQ     = RST_BITS;
        w_forceBits = 1'b1;
      end
      LOAD: begin
        w_nextQ     = WIDTH'(clampLoad(33'(d), 33'(MODULUS)));
        w_forceBits = 1'b1;
      end
      STEP: begin
        if (up == CNT_UP) begin
          if (w_atMax) begin
`ifdef UPDOWN_CNT_SAT_EN
            w_nextQ     = w_q;
`else
            w_nextQ     = '0;
            w_nextWrap  = 1'b1;
            w_forceBits = 1'b1;
`endif
          end else begin
            w_nextQ = w_inc[WIDTH-1:0];
          end
        end else begin
          if (w_atZero) begin
`ifdef UPDOWN_CNT_SAT_EN
            w_nextQ     = w_q;
`else
            w_nextQ     = MAX_VAL;
            w_nextWrap  = 1'b1;
            w_forceBits = 1'b1;
`endif
          end else begin
            w_nextQ = w_dec;
          end
        end
      end
      default: w_nextQ = w_q;
    endcase
  end

  // Plain steps toggle the bits that change; load and wrap set/reset every bit.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic w_j;
    logic w_k;
    assign w_j = w_forceBits ? w_nextQ[i]  : (w_nextQ[i] ^ w_q[i]);
    assign w_k = w_forceBits ? ~w_nextQ[i] : (w_nextQ[i] ^ w_q[i]);
    jk_sync_cell #(
      .RST_BIT(RST_BITS[i])
    ) u_cell (
      .clk(clk),
      .rst(rst),
      .j  (w_j),
      .k  (w_k),
      .q  (w_q[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) r_wrap <= 1'b0;
    else     r_wrap <= w_nextWrap;
  end

  assign q    = w_q;
  assign wrap = r_wrap;

endmodule
